ma_stage_sb: RTL and testbench

- Parametrised next-generation memory-access pipeline stage, sitting between EX and WB.
- Adds a configurable-depth store buffer, so retiring stores no longer stall on memory write acceptance.
- Generates byte-lane strobes and aligned write data for SW/SB/SH/SWL/SWR.
- Issues loads directly to memory, with a load-after-store word-address hazard check against every buffered store.
- Arbitrates one shared memory request port between stage loads and buffer drains.

---
 rtl/ma_pkg.sv | 28 ++
 rtl/ma_store_buffer.sv | 102 ++++++++++
 rtl/ma_stage_sb.sv | 170 +++++++++++++++++
 tb/tb_ma_stage_sb.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ma_pkg.sv
// ma_pkg: shared encodings for the memory-access stage and its store buffer.
//   - st_type_e : store type codes carried from EX
//   - SZ_*      : memory size codes driven on mem_size
//   - sb_data_t : payload of one store-buffer entry (word address is kept separately
//                 because its width follows ADDR_W)
package ma_pkg;

    typedef enum logic [2:0] {
        ST_SW  = 3'd0,
        ST_SB  = 3'd1,
        ST_SH  = 3'd2,
        ST_SWL = 3'd3,
        ST_SWR = 3'd4
    } st_type_e;

    localparam logic [2:0] SZ_B = 3'd0;
    localparam logic [2:0] SZ_H = 3'd1;
    localparam logic [2:0] SZ_W = 3'd2;

    typedef struct packed {
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [2:0]  size;
    } sb_data_t;

    localparam int unsigned SB_DATA_W = $bits(sb_data_t);

endpackage

// File: rtl/ma_store_buffer.sv
// ma_store_buffer: FIFO of retired stores awaiting memory acceptance.
// Ports:
//   clk, rst_p          clock, synchronous active-high reset (pointers/count/valids)
//   push, push_waddr,   enqueue a store at the tail (ignored when full)
//   push_data
//   pop                 dequeue the head entry (ignored when empty)
//   cmp_waddr, hazard   word address compared against every valid entry
//   full, empty, count  occupancy; derived from count, never from pointer equality
//   head_waddr,         head entry contents, stable until popped
//   head_data
module ma_store_buffer
    import ma_pkg::*;
#(
    parameter int unsigned SB_DEPTH = 4,
    parameter int unsigned ADDR_W   = 32
) (
    input  logic                       clk,
    input  logic                       rst_p,
    input  logic                       push,
    input  logic [ADDR_W-3:0]          push_waddr,
    input  sb_data_t                   push_data,
    input  logic                       pop,
    input  logic [ADDR_W-3:0]          cmp_waddr,
    output logic                       hazard,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(SB_DEPTH):0]  count,
    output logic [ADDR_W-3:0]          head_waddr,
    output sb_data_t                   head_data
);

    localparam int unsigned PTR_W = $clog2(SB_DEPTH);

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [PTR_W:0]    count_q, count_d;
    logic [SB_DEPTH-1:0] vld_q, vld_d;
    logic [ADDR_W-3:0] waddr_q [SB_DEPTH];
    sb_data_t          data_q  [SB_DEPTH];
    logic              do_push, do_pop;

    assign full    = (count_q == (PTR_W+1)'(SB_DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign head_waddr = waddr_q[head_q];
    assign head_data  = data_q[head_q];

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        vld_d   = vld_q;
        if (do_pop) begin
            head_d        = head_q + PTR_W'(1);
            vld_d[head_q] = 1'b0;
        end
        if (do_push) begin
            tail_d        = tail_q + PTR_W'(1);
            vld_d[tail_q] = 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Per-entry valid bits make the hazard compare independent of head/tail math.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (vld_q[i] && (waddr_q[i] == cmp_waddr)) begin
                hazard = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_p) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            vld_q   <= vld_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            waddr_q[tail_q] <= push_waddr;
            data_q[tail_q]  <= push_data;
        end
    end

endmodule

// File: rtl/ma_stage_sb.sv
// ma_stage_sb: memory-access pipeline stage (EX -> WB) with a store buffer.
// Ports:
//   clk, rst_p            clock, synchronous active-high reset
//   flush                 kill the instruction held in the stage
//   in_*                  instruction from EX (valid/ready handshake)
//   out_valid/out_ready   handshake to WB; out_exccode is the registered exccode
//   mem_*                 single shared memory request port (loads and store drains)
//   sb_empty, sb_count    store-buffer occupancy
// Loads go straight to memory unless an older buffered store targets the same word.
module ma_stage_sb
    import ma_pkg::*;
#(
    parameter int unsigned SB_DEPTH = 4,
    parameter int unsigned ADDR_W   = 32
) (
    input  logic                       clk,
    input  logic                       rst_p,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_load,
    input  logic                       in_store,
    input  logic [2:0]                 in_st_type,
    input  logic [2:0]                 in_ld_size,
    input  logic [ADDR_W-1:0]          in_addr,
    input  logic [31:0]                in_wdata,
    input  logic [4:0]                 in_exccode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [4:0]                 out_exccode,
    output logic                       mem_req,
    output logic                       mem_wr,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [2:0]                 mem_size,
    output logic [3:0]                 mem_wstrb,
    output logic [31:0]                mem_wdata,
    input  logic                       mem_gnt,
    output logic                       sb_empty,
    output logic [$clog2(SB_DEPTH):0]  sb_count
);

    logic              valid_q;
    logic              load_q, store_q;
    st_type_e          st_type_q;
    logic [2:0]        ld_size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [4:0]        exc_q;

    logic              no_exc, stall, leaving, coming, commit;
    logic              load_req, load_gnt, drain;
    logic              sb_full, hazard;
    logic [ADDR_W-3:0] head_waddr;
    sb_data_t          head_data, st_entry;
    logic [1:0]        off;

    assign no_exc = (exc_q == 5'd0);
    assign off    = addr_q[1:0];

    // Arbitration uses only registered state plus out_ready/mem_gnt.
    assign load_req = valid_q && load_q && no_exc && !hazard && out_ready;
    assign load_gnt = load_req && mem_gnt;
    assign drain    = !load_req && !sb_empty && mem_gnt;

    // Store stall ignores a same-cycle drain so mem_gnt never reaches in_ready via stores.
    assign stall   = no_exc && ((store_q && sb_full) || (load_q && (hazard || !load_gnt)));
    assign leaving = valid_q && out_ready && !stall;
    assign in_ready = !valid_q || leaving;
    assign coming   = in_valid && in_ready;
    assign commit   = leaving && store_q && no_exc && !flush;

    assign out_valid   = valid_q;
    assign out_exccode = exc_q;

    always_ff @(posedge clk) begin
        if (rst_p) begin
            valid_q   <= 1'b0;
            load_q    <= 1'b0;
            store_q   <= 1'b0;
            st_type_q <= ST_SW;
            ld_size_q <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            exc_q     <= '0;
        end else begin
            if (flush) begin
                valid_q <= 1'b0;
            end else if (coming) begin
                valid_q <= 1'b1;
            end else if (leaving) begin
                valid_q <= 1'b0;
            end
            if (coming && !flush) begin
                load_q    <= in_load;
                store_q   <= in_store;
                st_type_q <= st_type_e'(in_st_type);
                ld_size_q <= in_ld_size;
                addr_q    <= in_addr;
                wdata_q   <= in_wdata;
                exc_q     <= in_exccode;
            end
        end
    end

    // Byte-lane strobes and lane-aligned data for the store in the stage.
    always_comb begin
        st_entry.wstrb = 4'b0000;
        st_entry.wdata = wdata_q;
        st_entry.size  = SZ_W;
        case (st_type_q)
            ST_SW: st_entry.wstrb = 4'b1111;
            ST_SB: begin
                st_entry.wstrb = 4'b0001 << off;
                st_entry.wdata = {24'd0, wdata_q[7:0]} << {off, 3'b000};
                st_entry.size  = SZ_B;
            end
            ST_SH: begin
                st_entry.wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
                st_entry.wdata = addr_q[1] ? {wdata_q[15:0], 16'd0} : {16'd0, wdata_q[15:0]};
                st_entry.size  = SZ_H;
            end
            ST_SWL: begin
                st_entry.wstrb = {off == 2'd3, off[1], off != 2'd0, 1'b1};
                // ~off == 3 - off for a 2-bit offset
                st_entry.wdata = wdata_q >> {~off, 3'b000};
            end
            ST_SWR: begin
                st_entry.wstrb = {1'b1, off != 2'd3, !off[1], off == 2'd0};
                st_entry.wdata = wdata_q << {off, 3'b000};
            end
            default: st_entry.wstrb = 4'b0000;
        endcase
    end

    ma_store_buffer #(
        .SB_DEPTH (SB_DEPTH),
        .ADDR_W   (ADDR_W)
    ) u_sb (
        .clk        (clk),
        .rst_p      (rst_p),
        .push       (commit),
        .push_waddr (addr_q[ADDR_W-1:2]),
        .push_data  (st_entry),
        .pop        (drain),
        .cmp_waddr  (addr_q[ADDR_W-1:2]),
        .hazard     (hazard),
        .full       (sb_full),
        .empty      (sb_empty),
        .count      (sb_count),
        .head_waddr (head_waddr),
        .head_data  (head_data)
    );

    // Load wins; otherwise the head entry is presented whenever the buffer is non-empty.
    always_comb begin
        mem_req   = load_req || !sb_empty;
        mem_wr    = !load_req;
        mem_addr  = {head_waddr, 2'b00};
        mem_size  = head_data.size;
        mem_wstrb = head_data.wstrb;
        mem_wdata = head_data.wdata;
        if (load_req) begin
            mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
            mem_size  = ld_size_q;
            mem_wstrb = 4'b0000;
            mem_wdata = 32'd0;
        end
    end

endmodule

// File: tb/tb_ma_stage_sb.sv
// Directed bench for ma_stage_sb: store alignment, buffer full/drain, hazards,
// arbitration, exception, flush and reset.
module tb_ma_stage_sb;
    import ma_pkg::*;

    localparam int unsigned SB_DEPTH = 4;
    localparam int unsigned ADDR_W   = 32;

    logic        clk = 1'b0;
    logic        rst_p, flush;
    logic        in_valid, in_ready, in_load, in_store;
    logic [2:0]  in_st_type, in_ld_size;
    logic [31:0] in_addr, in_wdata;
    logic [4:0]  in_exccode;
    logic        out_valid, out_ready;
    logic [4:0]  out_exccode;
    logic        mem_req, mem_wr, mem_gnt;
    logic [31:0] mem_addr, mem_wdata;
    logic [2:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic        sb_empty;
    logic [2:0]  sb_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ma_stage_sb #(
        .SB_DEPTH (SB_DEPTH),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst_p       (rst_p),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_load     (in_load),
        .in_store    (in_store),
        .in_st_type  (in_st_type),
        .in_ld_size  (in_ld_size),
        .in_addr     (in_addr),
        .in_wdata    (in_wdata),
        .in_exccode  (in_exccode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_exccode (out_exccode),
        .mem_req     (mem_req),
        .mem_wr      (mem_wr),
        .mem_addr    (mem_addr),
        .mem_size    (mem_size),
        .mem_wstrb   (mem_wstrb),
        .mem_wdata   (mem_wdata),
        .mem_gnt     (mem_gnt),
        .sb_empty    (sb_empty),
        .sb_count    (sb_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic put(input logic ld, input logic st, input logic [2:0] ty,
                       input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] exc);
        in_valid   = 1'b1;
        in_load    = ld;
        in_store   = st;
        in_st_type = ty;
        in_ld_size = sz;
        in_addr    = a;
        in_wdata   = d;
        in_exccode = exc;
    endtask

    task automatic clr();
        in_valid   = 1'b0;
        in_load    = 1'b0;
        in_store   = 1'b0;
        in_exccode = 5'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_p = 1'b1; flush = 1'b0; mem_gnt = 1'b0; out_ready = 1'b1;
        in_st_type = 3'd0; in_ld_size = 3'd0; in_addr = '0; in_wdata = '0;
        clr();
        tick(); tick();
        rst_p = 1'b0;
        settle();
        check("rst_out_valid", out_valid, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_sb_empty", sb_empty, 1);
        check("rst_sb_count", sb_count, 0);
        check("rst_in_ready", in_ready, 1);

        // SB at 0x1003 lands in lane 3
        put(0, 1, ST_SB, 0, 32'h1003, 32'h0000_00AB, 0);
        tick(); clr(); settle();
        check("sb_out_valid", out_valid, 1);
        check("sb_leave_ready", in_ready, 1);
        tick(); settle();
        check("sb_left", out_valid, 0);
        check("sb_count1", sb_count, 1);
        check("sb_req", mem_req, 1);
        check("sb_wr", mem_wr, 1);
        check("sb_addr", mem_addr, 32'h1000);
        check("sb_wstrb", mem_wstrb, 4'b1000);
        check("sb_wdata", mem_wdata, 32'hAB00_0000);
        check("sb_size", mem_size, 0);
        mem_gnt = 1'b1;
        tick(); mem_gnt = 1'b0; settle();
        check("sb_drained", sb_empty, 1);
        check("sb_idle_req", mem_req, 0);

        // Fill with four SW, fifth stalls
        for (int i = 0; i < 5; i++) begin
            put(0, 1, ST_SW, 0, 32'h100 + 32'(4 * i), 32'(i + 1), 0);
            tick();
        end
        clr(); settle();
        check("full_count", sb_count, 4);
        check("full_stall", in_ready, 0);
        check("full_held", out_valid, 1);
        check("full_head", mem_addr, 32'h100);
        mem_gnt = 1'b1; settle();
        check("full_no_credit", in_ready, 0);
        tick(); mem_gnt = 1'b0; settle();
        check("full_after_drain", sb_count, 3);
        check("full_fifth_go", in_ready, 1);
        check("full_head2", mem_addr, 32'h104);
        tick(); settle();
        check("full_again", sb_count, 4);
        check("full_fifth_left", out_valid, 0);
        for (int i = 0; i < 4; i++) begin
            mem_gnt = 1'b1; settle();
            check("fifo_addr", mem_addr, 32'h104 + 32'(4 * i));
            check("fifo_data", mem_wdata, 32'(i + 2));
            tick();
        end
        mem_gnt = 1'b0; settle();
        check("fifo_empty", sb_empty, 1);

        // Load-after-store hazard on the same word
        put(0, 1, ST_SW, 0, 32'h2000, 32'h55, 0);
        tick(); clr(); tick(); settle();
        check("hz_count", sb_count, 1);
        put(1, 0, 0, SZ_W, 32'h2002, 0, 0);
        tick(); clr(); settle();
        check("hz_stall", in_ready, 0);
        check("hz_drain_wr", mem_wr, 1);
        check("hz_drain_addr", mem_addr, 32'h2000);
        tick(); settle();
        check("hz_still_held", out_valid, 1);
        check("hz_still_drain", mem_wr, 1);
        mem_gnt = 1'b1;
        tick(); mem_gnt = 1'b0; settle();
        check("hz_cleared", sb_count, 0);
        check("ld_req", mem_req, 1);
        check("ld_wr", mem_wr, 0);
        check("ld_addr", mem_addr, 32'h2000);
        check("ld_size", mem_size, 2);
        mem_gnt = 1'b1; settle();
        check("ld_gnt_ready", in_ready, 1);
        tick(); mem_gnt = 1'b0; settle();
        check("ld_left", out_valid, 0);
        check("ld_idle", mem_req, 0);

        // Load to another word beats a pending drain
        put(0, 1, ST_SW, 0, 32'h3000, 32'h77, 0);
        tick(); clr(); tick();
        put(1, 0, 0, SZ_W, 32'h4000, 0, 0);
        tick(); clr(); mem_gnt = 1'b1; settle();
        check("arb_ld_wins", mem_wr, 0);
        check("arb_ld_addr", mem_addr, 32'h4000);
        check("arb_sb_kept", sb_count, 1);
        tick(); settle();
        check("arb_ld_left", out_valid, 0);
        check("arb_drain_wr", mem_wr, 1);
        check("arb_drain_addr", mem_addr, 32'h3000);
        tick(); mem_gnt = 1'b0; settle();
        check("arb_empty", sb_empty, 1);

        // SWL / SWR / SH alignment
        put(0, 1, ST_SWL, 0, 32'h5001, 32'h1122_3344, 0);
        tick();
        put(0, 1, ST_SWR, 0, 32'h5001, 32'h1122_3344, 0);
        tick();
        put(0, 1, ST_SH, 0, 32'h6002, 32'h0000_BEEF, 0);
        tick(); clr(); tick(); settle();
        check("al_count", sb_count, 3);
        check("swl_wstrb", mem_wstrb, 4'b0011);
        check("swl_wdata", mem_wdata, 32'h0000_1122);
        check("swl_size", mem_size, 2);
        mem_gnt = 1'b1;
        tick(); settle();
        check("swr_wstrb", mem_wstrb, 4'b1110);
        check("swr_wdata", mem_wdata, 32'h2233_4400);
        check("swr_size", mem_size, 2);
        tick(); settle();
        check("sh_addr", mem_addr, 32'h6000);
        check("sh_wstrb", mem_wstrb, 4'b1100);
        check("sh_wdata", mem_wdata, 32'hBEEF_0000);
        check("sh_size", mem_size, 1);
        tick(); mem_gnt = 1'b0; settle();
        check("al_empty", sb_empty, 1);

        // Excepting store leaves without writing the buffer
        put(0, 1, ST_SW, 0, 32'h7000, 32'h99, 5'd4);
        tick(); clr(); settle();
        check("exc_code", out_exccode, 4);
        check("exc_ready", in_ready, 1);
        tick(); settle();
        check("exc_left", out_valid, 0);
        check("exc_no_entry", sb_empty, 1);

        // Flush a stalled load
        put(1, 0, 0, SZ_W, 32'h8000, 0, 0);
        tick(); clr(); settle();
        check("fl_req", mem_req, 1);
        check("fl_addr", mem_addr, 32'h8000);
        check("fl_stall", in_ready, 0);
        flush = 1'b1;
        tick(); flush = 1'b0; settle();
        check("fl_killed", out_valid, 0);
        check("fl_req_drop", mem_req, 0);

        // Reset with three buffered stores
        for (int i = 0; i < 3; i++) begin
            put(0, 1, ST_SW, 0, 32'h9000 + 32'(4 * i), 32'(i), 0);
            tick();
        end
        clr(); tick(); settle();
        check("pre_rst_count", sb_count, 3);
        rst_p = 1'b1;
        tick(); rst_p = 1'b0; settle();
        check("rst2_empty", sb_empty, 1);
        check("rst2_req", mem_req, 0);
        check("rst2_count", sb_count, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
